// File: rtl/regm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regm_pkg
//  Description : Shared types and constants for the regm writeback path.
//                Defines register-file geometry, the writeback request
//                payload and a one-hot decode helper for hazard masks.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package regm_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    // One-hot decode of a register address into a NUM_REGS-wide mask.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] m;
        m    = '0;
        m[a] = 1'b1;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regm_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : regm_wb_fifo
//  Description : Small in-order queue of writeback requests. Besides the
//                usual push/pop/full/empty it exposes every storage slot and
//                a per-slot valid vector so the owner can build a mask of
//                registers with writes still outstanding.
//  Ports       : clk, rst_n       - clock / async active-low reset
//                i_push, i_req    - enqueue request (ignored when full)
//                i_pop            - dequeue head (ignored when empty)
//                o_full, o_empty  - occupancy flags
//                o_head           - oldest entry
//                o_entries        - raw storage slots
//                o_entry_vld      - slot holds a queued request
//  Parameters  : DEPTH - entries, power of two, >= 2
//  Revision    : 1.0 - initial release
// ============================================================================
module regm_wb_fifo
    import regm_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_push,
    input  wb_req_t             i_req,
    input  logic                i_pop,
    output logic                o_full,
    output logic                o_empty,
    output wb_req_t             o_head,
    output wb_req_t [DEPTH-1:0] o_entries,
    output logic    [DEPTH-1:0] o_entry_vld
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(DEPTH);

    wb_req_t [DEPTH-1:0] r_mem;
    logic    [PTR_W-1:0] r_wr_ptr;
    logic    [PTR_W-1:0] r_rd_ptr;
    logic    [CNT_W-1:0] r_count;
    logic    [DEPTH-1:0] r_vld;
    logic    [DEPTH-1:0] w_vld_next;
    logic                w_push;
    logic                w_pop;

    assign o_full      = (r_count == C_FULL_CNT);
    assign o_empty     = (r_count == '0);
    assign w_push      = i_push && !o_full;
    assign w_pop       = i_pop && !o_empty;
    assign o_head      = r_mem[r_rd_ptr];
    assign o_entries   = r_mem;
    assign o_entry_vld = r_vld;

    // Slot valid bits track occupancy per slot; a push and a pop in the same
    // cycle always touch different slots because the queue is non-empty.
    always_comb begin
        w_vld_next = r_vld;
        if (w_pop) begin
            w_vld_next[r_rd_ptr] = 1'b0;
        end
        if (w_push) begin
            w_vld_next[r_wr_ptr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_req;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            r_vld <= w_vld_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regm_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regm_wb_arbiter
//  Description : Shares the single regm write port between the ALU result
//                (src0) and the load return (src1). Each source feeds its own
//                queue; a round-robin arbiter commits at most one write per
//                cycle onto registered regwrite/wrreg/wrdata. Writes to r0 are
//                consumed without asserting regwrite. pend_mask flags every
//                register with a write queued or on the regm port.
//  Ports       : clk, rst_n                  - clock / async active-low reset
//                sN_valid/ready/addr/data     - source N request handshake
//                regwrite, wrreg, wrdata      - registered regm write port
//                pend_mask                    - outstanding-write mask
//                busy                         - queues or port active
//                read1/2, data1/2, fwd_data1/2- regm read bypass (optional)
//  Config      : REGM_BYPASS_EN - adds the read-port forwarding mux
//  Parameters  : DEPTH - entries per source queue, power of two, >= 2
//  Revision    : 1.0 - initial release
// ============================================================================
module regm_wb_arbiter
    import regm_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic [REG_ADDR_W-1:0] s0_addr,
    input  logic [REG_DATA_W-1:0] s0_data,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic [REG_ADDR_W-1:0] s1_addr,
    input  logic [REG_DATA_W-1:0] s1_data,
    output logic                  regwrite,
    output logic [REG_ADDR_W-1:0] wrreg,
    output logic [REG_DATA_W-1:0] wrdata,
    output logic [NUM_REGS-1:0]   pend_mask,
    output logic                  busy
`ifdef REGM_BYPASS_EN
    ,
    input  logic [REG_ADDR_W-1:0] read1,
    input  logic [REG_ADDR_W-1:0] read2,
    input  logic [REG_DATA_W-1:0] data1,
    input  logic [REG_DATA_W-1:0] data2,
    output logic [REG_DATA_W-1:0] fwd_data1,
    output logic [REG_DATA_W-1:0] fwd_data2
`endif
);

    localparam int NUM_SRC = 2;

    logic                w_push   [NUM_SRC];
    wb_req_t             w_req_in [NUM_SRC];
    logic                w_pop    [NUM_SRC];
    logic                w_full   [NUM_SRC];
    logic                w_empty  [NUM_SRC];
    wb_req_t             w_head   [NUM_SRC];
    wb_req_t [DEPTH-1:0] w_entries[NUM_SRC];
    logic    [DEPTH-1:0] w_vld    [NUM_SRC];

    logic                  w_grant_vld;
    logic                  w_grant_sel;
    wb_req_t               w_win;
    logic [NUM_REGS-1:0]   w_pend;

    // r_rr names the source that wins the next tie; it flips to the other
    // source after every grant, so saturated sources alternate 0,1,0,1.
    logic                  r_rr;
    logic                  r_regwrite;
    logic [REG_ADDR_W-1:0] r_wrreg;
    logic [REG_DATA_W-1:0] r_wrdata;

    assign w_push[0]   = s0_valid;
    assign w_push[1]   = s1_valid;
    assign w_req_in[0] = '{addr: s0_addr, data: s0_data};
    assign w_req_in[1] = '{addr: s1_addr, data: s1_data};

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            regm_wb_fifo #(
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_push      (w_push[gi]),
                .i_req       (w_req_in[gi]),
                .i_pop       (w_pop[gi]),
                .o_full      (w_full[gi]),
                .o_empty     (w_empty[gi]),
                .o_head      (w_head[gi]),
                .o_entries   (w_entries[gi]),
                .o_entry_vld (w_vld[gi])
            );
        end
    endgenerate

    // Ready never depends on a same-cycle pop, and is held low in reset.
    assign s0_ready = rst_n && !w_full[0];
    assign s1_ready = rst_n && !w_full[1];

    always_comb begin
        w_grant_vld = !w_empty[0] || !w_empty[1];
        if (!w_empty[0] && !w_empty[1]) begin
            w_grant_sel = r_rr;
        end else begin
            w_grant_sel = w_empty[0];
        end
        w_win    = w_grant_sel ? w_head[1] : w_head[0];
        w_pop[0] = w_grant_vld && !w_grant_sel;
        w_pop[1] = w_grant_vld &&  w_grant_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr       <= 1'b0;
            r_regwrite <= 1'b0;
            r_wrreg    <= '0;
            r_wrdata   <= '0;
        end else begin
            if (w_grant_vld) begin
                r_rr       <= !w_grant_sel;
                // r0 is hardwired zero: the request is consumed, no write issued.
                r_regwrite <= (w_win.addr != '0);
                r_wrreg    <= w_win.addr;
                r_wrdata   <= w_win.data;
            end else begin
                r_regwrite <= 1'b0;
            end
        end
    end

    always_comb begin
        w_pend = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (w_vld[s][e]) begin
                    w_pend = w_pend | reg_onehot(w_entries[s][e].addr);
                end
            end
        end
        if (r_regwrite) begin
            w_pend = w_pend | reg_onehot(r_wrreg);
        end
        w_pend[0] = 1'b0;
    end

    assign regwrite  = r_regwrite;
    assign wrreg     = r_wrreg;
    assign wrdata    = r_wrdata;
    assign pend_mask = w_pend;
    assign busy      = !w_empty[0] || !w_empty[1] || r_regwrite;

`ifdef REGM_BYPASS_EN
    // The value on the write port lands in regm at the next edge; forward it
    // so a same-cycle decode read sees the new value.
    assign fwd_data1 = (r_regwrite && (r_wrreg == read1) && (read1 != '0)) ? r_wrdata : data1;
    assign fwd_data2 = (r_regwrite && (r_wrreg == read2) && (read2 != '0)) ? r_wrdata : data2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regm_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regm_wb_arbiter
//  Description : Self-checking bench for regm_wb_arbiter. A queue-based
//                model tracks both source queues, the tie-break preference,
//                the regm port and a register-file image; a negedge compare
//                process checks every output each cycle. Directed phases pin
//                the model with literal expectations; a random phase follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regm_wb_arbiter;
    import regm_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic                  s0_valid, s1_valid;
    logic                  s0_ready, s1_ready;
    logic [REG_ADDR_W-1:0] s0_addr, s1_addr;
    logic [REG_DATA_W-1:0] s0_data, s1_data;
    logic                  regwrite;
    logic [REG_ADDR_W-1:0] wrreg;
    logic [REG_DATA_W-1:0] wrdata;
    logic [NUM_REGS-1:0]   pend_mask;
    logic                  busy;
`ifdef REGM_BYPASS_EN
    logic [REG_ADDR_W-1:0] read1, read2;
    logic [REG_DATA_W-1:0] data1, data2, fwd_data1, fwd_data2;
`endif

    regm_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s0_valid  (s0_valid),
        .s0_ready  (s0_ready),
        .s0_addr   (s0_addr),
        .s0_data   (s0_data),
        .s1_valid  (s1_valid),
        .s1_ready  (s1_ready),
        .s1_addr   (s1_addr),
        .s1_data   (s1_data),
        .regwrite  (regwrite),
        .wrreg     (wrreg),
        .wrdata    (wrdata),
        .pend_mask (pend_mask),
        .busy      (busy)
`ifdef REGM_BYPASS_EN
        ,
        .read1     (read1),
        .read2     (read2),
        .data1     (data1),
        .data2     (data2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    // Behavioural model state
    ent_t        mq0[$];
    ent_t        mq1[$];
    int          prefer;          // source that wins the next tie
    logic        m_regwrite;
    logic [4:0]  m_wrreg;
    logic [31:0] m_wrdata;
    logic [31:0] m_rf [32];
    bit          acc0, acc1;
    bit          chk_en = 1'b0;
    int          commit_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        prefer     = 0;
        m_regwrite = 1'b0;
        m_wrreg    = '0;
        m_wrdata   = '0;
        acc0       = 1'b0;
        acc1       = 1'b0;
    endtask

    function automatic logic [31:0] m_pend();
        logic [31:0] m;
        m = '0;
        foreach (mq0[i]) m[mq0[i].a] = 1'b1;
        foreach (mq1[i]) m[mq1[i].a] = 1'b1;
        if (m_regwrite) m[m_wrreg] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // Advance the model by one rising edge using the inputs held before it.
    task automatic model_edge();
        ent_t e;
        int   g;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_regwrite) m_rf[m_wrreg] = m_wrdata;
        acc0 = s0_valid && (mq0.size() < DEPTH);
        acc1 = s1_valid && (mq1.size() < DEPTH);
        g = -1;
        if (mq0.size() > 0 && mq1.size() > 0) g = prefer;
        else if (mq0.size() > 0)              g = 0;
        else if (mq1.size() > 0)              g = 1;
        if (g >= 0) begin
            if (g == 0) e = mq0.pop_front();
            else        e = mq1.pop_front();
            m_regwrite = (e.a != 5'd0);
            m_wrreg    = e.a;
            m_wrdata   = e.d;
            prefer     = 1 - g;
        end else begin
            m_regwrite = 1'b0;
        end
        if (acc0) mq0.push_back('{s0_addr, s0_data});
        if (acc1) mq1.push_back('{s1_addr, s1_data});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic pulse_reset();
        rst_n    = 1'b0;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("s0_ready", s0_ready, rst_n && (mq0.size() < DEPTH));
            check("s1_ready", s1_ready, rst_n && (mq1.size() < DEPTH));
            check("regwrite", regwrite, m_regwrite);
            if (m_regwrite) begin
                check("wrreg", wrreg, m_wrreg);
                check("wrdata", wrdata, m_wrdata);
            end
            check("pend_mask", pend_mask, m_pend());
            check("busy", busy, (mq0.size() > 0) || (mq1.size() > 0) || m_regwrite);
`ifdef REGM_BYPASS_EN
            check("fwd_data1", fwd_data1,
                  (m_regwrite && m_wrreg == read1 && read1 != 0) ? m_wrdata : data1);
            check("fwd_data2", fwd_data2,
                  (m_regwrite && m_wrreg == read2 && read2 != 0) ? m_wrdata : data2);
`endif
            if (regwrite) commit_log.push_back(int'(wrreg));
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        check({name, "_drain_timeout"}, busy, 1'b0);
    endtask

    initial begin
        int i0, i1, lows0, lows1, rw_cnt, p0, p1;
        int exp_order[8];
        exp_order = '{1, 11, 2, 12, 3, 13, 4, 14};

        for (int r = 0; r < 32; r++) m_rf[r] = '0;
        rst_n = 1'b1;
        s0_valid = 1'b1; s0_addr = 5'd3; s0_data = 32'h0000_0033;
        s1_valid = 1'b0; s1_addr = '0;   s1_data = '0;
`ifdef REGM_BYPASS_EN
        read1 = '0; read2 = '0; data1 = '0; data2 = '0;
`endif
        model_reset();
        #2 rst_n = 1'b0;

        // Reset held 5 cycles with s0 requesting
        repeat (5) begin
            step();
            chk_en = 1'b1;
        end
        check("rst_regwrite", regwrite, 1'b0);
        check("rst_s0_ready", s0_ready, 1'b0);
        check("rst_pend_mask", pend_mask, 32'h0);
        check("rst_busy", busy, 1'b0);
        s0_valid = 1'b0;
        rst_n    = 1'b1;
        step();

        // Single write to r5
        s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'h0000_1234;
        step();
        s0_valid = 1'b0;
        check("single_pend_accept", pend_mask[5], 1'b1);
        step();
        check("single_regwrite", regwrite, 1'b1);
        check("single_wrreg", wrreg, 32'd5);
        check("single_wrdata", wrdata, 32'h0000_1234);
        check("single_pend_commit", pend_mask[5], 1'b1);
        step();
        check("single_regwrite_off", regwrite, 1'b0);
        check("single_pend_clear", pend_mask[5], 1'b0);
        check("single_rf_r5", m_rf[5], 32'h0000_1234);

        // Contention from a fresh tie-break state
        pulse_reset();
        commit_log.delete();
        i0 = 0; i1 = 0; lows0 = 0; lows1 = 0;
        s0_valid = 1'b1; s1_valid = 1'b1;
        for (int c = 0; c < 40 && (i0 < 4 || i1 < 4); c++) begin
            if (i0 < 4) begin s0_addr = 5'(1 + i0);  s0_data = 32'hA000 + 32'(i0); end
            if (i1 < 4) begin s1_addr = 5'(11 + i1); s1_data = 32'hB000 + 32'(i1); end
            step();
            if (acc0) i0++;
            if (acc1) i1++;
            if (i0 >= 4) s0_valid = 1'b0;
            if (i1 >= 4) s1_valid = 1'b0;
            if (!s0_ready) lows0++;
            if (!s1_ready) lows1++;
        end
        drain("contention");
        check("cont_s0_ready_dropped", lows0 > 0, 1'b1);
        check("cont_s1_ready_dropped", lows1 > 0, 1'b1);
        check("cont_commit_count", commit_log.size(), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < commit_log.size())
                check($sformatf("cont_order_%0d", k), commit_log[k], exp_order[k]);
        end

        // Write to r0 is consumed silently
        s1_valid = 1'b1; s1_addr = 5'd0; s1_data = 32'h0000_FFFF;
        step();
        s1_valid = 1'b0;
        check("r0_pend_mask", pend_mask, 32'h0);
        check("r0_busy_queued", busy, 1'b1);
        step();
        check("r0_regwrite", regwrite, 1'b0);
        check("r0_busy_after", busy, 1'b0);
        check("r0_rf", m_rf[0], 32'h0);

        // Reset in the middle of traffic
        s0_valid = 1'b1; s0_addr = 5'd9;  s0_data = 32'h0000_0909;
        s1_valid = 1'b1; s1_addr = 5'd20; s1_data = 32'h0000_2020;
        repeat (3) step();
        check("mid_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        s0_valid = 1'b0; s1_valid = 1'b0;
        model_reset();
        #1;
        check("mid_busy_async", busy, 1'b0);
        check("mid_regwrite_async", regwrite, 1'b0);
        step();
        rst_n = 1'b1;
        rw_cnt = 0;
        repeat (5) begin
            step();
            if (regwrite) rw_cnt++;
        end
        check("mid_no_regwrite", rw_cnt, 32'd0);

`ifdef REGM_BYPASS_EN
        // Forward a write on the port to a same-cycle read
        s0_valid = 1'b1; s0_addr = 5'd7; s0_data = 32'h0000_ABCD;
        step();
        s0_valid = 1'b0;
        step();
        read1 = 5'd7; data1 = 32'h5555_5555;
        read2 = 5'd0; data2 = 32'h7777_7777;
        #1;
        check("byp_fwd1", fwd_data1, 32'h0000_ABCD);
        check("byp_fwd2", fwd_data2, 32'h7777_7777);
        step();
`endif

        // Random traffic with varying load
        for (int blk = 0; blk < 6; blk++) begin
            p0 = 20 + 15 * blk;
            p1 = 95 - 15 * blk;
            for (int c = 0; c < 100; c++) begin
                if (!(s0_valid && !acc0)) begin
                    s0_valid = ($urandom_range(99) < p0);
                    s0_addr  = 5'($urandom_range(31));
                    s0_data  = $urandom;
                end
                if (!(s1_valid && !acc1)) begin
                    s1_valid = ($urandom_range(99) < p1);
                    s1_addr  = 5'($urandom_range(31));
                    s1_data  = $urandom;
                end
`ifdef REGM_BYPASS_EN
                read1 = 5'($urandom_range(31)); data1 = $urandom;
                read2 = 5'($urandom_range(31)); data2 = $urandom;
`endif
                step();
            end
        end
        drain("random");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
